// File: rtl/note_sequencer.sv
// Walks a per-song note list in an external synchronous ROM and hands one note
// at a time to note_player, waiting for its done indication before advancing.
module note_sequencer #(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [SONG_BITS-1:0]           song_sel,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                    rom_data,
    output logic [5:0]                     note_to_load,
    output logic [5:0]                     duration_to_load,
    output logic                           new_note,
    input  logic                           note_done,
    output logic                           song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROM_WAIT,
        S_DECODE,
        S_ARM,
        S_PLAY,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam logic [NOTE_BITS-1:0] LAST_INDEX = '1;

    state_t                         state_q, state_d;
    logic [NOTE_BITS-1:0]           index_q, index_d;
    logic [SONG_BITS-1:0]           cur_song_q, cur_song_d;
    logic [SONG_BITS+NOTE_BITS-1:0] rom_addr_q, rom_addr_d;
    logic [5:0]                     note_q, note_d;
    logic [5:0]                     dur_q, dur_d;
    logic                           new_note_q, new_note_d;
    logic                           song_done_q, song_done_d;
    logic                           song_change;

    assign song_change = (song_sel != cur_song_q);

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        cur_song_d = cur_song_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        dur_d      = dur_q;
        new_note_d = 1'b0;

        // A song change outranks everything except reset, including a pending strobe.
        if (song_change && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            index_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    index_d = '0;
                    if (play) begin
                        cur_song_d = song_sel;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    rom_addr_d = {cur_song_q, index_q};
                    if (play) state_d = S_ROM_WAIT;
                end
                S_ROM_WAIT: state_d = S_DECODE;
                S_DECODE: begin
                    if (rom_data[5:0] == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        note_d     = rom_data[11:6];
                        dur_d      = rom_data[5:0];
                        new_note_d = 1'b1;
                        state_d    = S_ARM;
                    end
                end
                // Clear a done level left over from the previous note.
                S_ARM: if (!note_done) state_d = S_PLAY;
                S_PLAY: if (note_done) state_d = S_ADVANCE;
                S_ADVANCE: begin
                    if (play) begin
                        if (index_q == LAST_INDEX) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: if (song_change) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        song_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            cur_song_q  <= '0;
            rom_addr_q  <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cur_song_q  <= cur_song_d;
            rom_addr_q  <= rom_addr_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign new_note         = new_note_q;
    assign song_done        = song_done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: ROM model, scripted player scenarios
// and randomized songs compared against a list-level reference model.
module tb_note_sequencer;

    typedef struct {
        logic [5:0] note;
        logic [5:0] dur;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song_sel;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        new_note;
    logic        note_done;
    logic        song_done;

    logic [11:0] rom [128];

    int total = 0;
    int bad   = 0;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  st_q[$];
    int  dn_q[$];
    int  sd_t;
    bit  wrap_seen;
    bit  finished;

    note_sequencer #(.SONG_BITS(2), .NOTE_BITS(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song_sel         (song_sel),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .new_note         (new_note),
        .note_done        (note_done),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        play      = 1'b0;
        note_done = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference: a song is its entries up to the first zero duration, at most 32.
    task automatic build_expected(input int unsigned song);
        logic [11:0] w;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            w = rom[song*32 + i];
            if (w[5:0] == 6'd0) break;
            exp_q.push_back('{note: w[11:6], dur: w[5:0]});
        end
    endtask

    // Plays a song with a player that raises note_done dmin..dmax steps after each strobe.
    task automatic run_song(input int unsigned song, input int unsigned dmin,
                            input int unsigned dmax, input bit rand_pause, input int budget);
        int cnt;
        int extra;
        bit idx_moved;
        got_q.delete();
        st_q.delete();
        dn_q.delete();
        sd_t      = -1;
        wrap_seen = 1'b0;
        finished  = 1'b0;
        idx_moved = 1'b0;
        cnt       = -1;
        extra     = 0;
        song_sel  = song[1:0];
        note_done = 1'b0;
        play      = 1'b1;
        for (int t = 1; t <= budget; t++) begin
            step();
            if (rand_pause) play = ($urandom_range(0, 3) != 0);
            if (rom_addr[4:0] != 5'd0) idx_moved = 1'b1;
            else if (idx_moved) wrap_seen = 1'b1;
            if (new_note) begin
                got_q.push_back('{note: note_to_load, dur: duration_to_load});
                st_q.push_back(t);
                note_done = 1'b0;
                cnt = int'($urandom_range(dmax, dmin));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    note_done = 1'b1;
                    dn_q.push_back(t);
                    cnt = -1;
                end
            end
            if (song_done) begin
                if (sd_t < 0) sd_t = t;
                finished = 1'b1;
                extra++;
                if (extra >= 8) break;
            end
        end
        play = 1'b0;
    endtask

    task automatic compare_song(input string tag);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d strobes, want %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin
                bad++;
                $display("FAIL %s_note%0d: missing, want %0d/%0d", tag, i, exp_q[i].note, exp_q[i].dur);
            end else if (got_q[i].note !== exp_q[i].note || got_q[i].dur !== exp_q[i].dur) begin
                bad++;
                $display("FAIL %s_note%0d: got %0d/%0d want %0d/%0d", tag, i,
                         got_q[i].note, got_q[i].dur, exp_q[i].note, exp_q[i].dur);
            end
        end
        total++;
        if (finished !== 1'b1) begin
            bad++;
            $display("FAIL %s_song_done: got %0b want 1", tag, finished);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b0; note_done = 1'b0; song_sel = 2'd0;
        step();
        step();
        total++;
        if ({rom_addr, note_to_load, duration_to_load, new_note, song_done} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got addr=%0d note=%0d dur=%0d nn=%0b sd=%0b want all 0",
                     rom_addr, note_to_load, duration_to_load, new_note, song_done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        run_song(0, 20, 20, 1'b0, 300);
        build_expected(0);
        compare_song("basic");
        // play driven at step 0 is sampled by edge 1; strobe 3 edges later.
        total++;
        if (st_q.size() < 1 || st_q[0] !== 4) begin
            bad++;
            $display("FAIL first_strobe_latency: got %0d want 4", st_q.size() > 0 ? st_q[0] : -1);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st_q.size() < i + 2 || dn_q.size() < i + 1 || st_q[i+1] - dn_q[i] !== 5) begin
                bad++;
                $display("FAIL done_to_strobe%0d: got %0d want 5", i,
                         (st_q.size() >= i + 2 && dn_q.size() >= i + 1) ? st_q[i+1] - dn_q[i] : -1);
            end
        end
        total++;
        if (dn_q.size() < 3 || sd_t - dn_q[2] !== 5) begin
            bad++;
            $display("FAIL marker_song_done_time: got %0d want 5", dn_q.size() >= 3 ? sd_t - dn_q[2] : -1);
        end
    endtask

    task automatic test_wrap32();
        do_reset();
        run_song(2, 1, 4, 1'b0, 600);
        build_expected(2);
        compare_song("wrap32");
        total++;
        if (wrap_seen !== 1'b0) begin
            bad++;
            $display("FAIL wrap_index: got returned-to-0=%0b want 0", wrap_seen);
        end
        // Last index goes straight from ADVANCE to DONE.
        total++;
        if (dn_q.size() < 32 || sd_t - dn_q[31] !== 2) begin
            bad++;
            $display("FAIL wrap_song_done_time: got %0d want 2", dn_q.size() >= 32 ? sd_t - dn_q[31] : -1);
        end
    endtask

    task automatic test_arm_guard();
        int s1;
        s1 = -1;
        st_q.delete(); got_q.delete();
        do_reset();
        song_sel = 2'd0; note_done = 1'b1; play = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (new_note) begin
                st_q.push_back(t);
                got_q.push_back('{note: note_to_load, dur: duration_to_load});
                if (s1 < 0) s1 = t;
            end
            if (s1 >= 0 && t == s1 + 5) note_done = 1'b0;
            if (s1 >= 0 && t == s1 + 8) note_done = 1'b1;
        end
        total++;
        if (st_q.size() !== 2) begin
            bad++;
            $display("FAIL arm_guard_count: got %0d want 2", st_q.size());
        end
        total++;
        if (st_q.size() < 2 || st_q[1] !== s1 + 13 || got_q[1].note !== 6'd12 || got_q[1].dur !== 6'd2) begin
            bad++;
            $display("FAIL arm_guard_second: got t=%0d want t=%0d (12/2)",
                     st_q.size() >= 2 ? st_q[1] : -1, s1 + 13);
        end
        play = 1'b0;
    endtask

    task automatic test_pause();
        int s1;
        s1 = -1;
        st_q.delete(); got_q.delete();
        do_reset();
        song_sel = 2'd0; note_done = 1'b0; play = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            step();
            if (new_note) begin
                st_q.push_back(t);
                got_q.push_back('{note: note_to_load, dur: duration_to_load});
                if (s1 < 0) s1 = t;
            end
            if (s1 >= 0 && t == s1 + 3) play = 1'b0;
            if (s1 >= 0 && t == s1 + 5) note_done = 1'b1;
            if (s1 >= 0 && t == s1 + 15) play = 1'b1;
        end
        total++;
        if (st_q.size() !== 2) begin
            bad++;
            $display("FAIL pause_count: got %0d want 2", st_q.size());
        end
        total++;
        if (st_q.size() < 2 || st_q[1] !== s1 + 19 || got_q[1].note !== 6'd12 || got_q[1].dur !== 6'd2) begin
            bad++;
            $display("FAIL pause_resume: got t=%0d want t=%0d (12/2)",
                     st_q.size() >= 2 ? st_q[1] : -1, s1 + 19);
        end
        play = 1'b0;
    endtask

    task automatic test_song_change();
        int s1;
        int s2;
        s1 = -1; s2 = -1;
        st_q.delete(); got_q.delete();
        do_reset();
        song_sel = 2'd0; note_done = 1'b0; play = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            step();
            if (new_note) begin
                st_q.push_back(t);
                got_q.push_back('{note: note_to_load, dur: duration_to_load});
                if (s1 < 0) s1 = t;
                else if (s2 < 0) s2 = t;
            end
            if (s1 >= 0 && t == s1 + 4) song_sel = 2'd1;
            // Raise done, then switch back to song 0 while the next fetch sits in DECODE.
            if (s2 >= 0 && t == s2 + 3) note_done = 1'b1;
            if (s2 >= 0 && t == s2 + 7) song_sel = 2'd0;
        end
        total++;
        if (st_q.size() !== 3) begin
            bad++;
            $display("FAIL song_change_count: got %0d want 3", st_q.size());
        end
        total++;
        if (s2 !== s1 + 9 || got_q.size() < 2 || {got_q[1].note, got_q[1].dur} !== rom[32]) begin
            bad++;
            $display("FAIL song_change_first: got t=%0d want t=%0d word=%0h", s2, s1 + 9, rom[32]);
        end
        total++;
        if (st_q.size() < 3 || st_q[2] !== s2 + 12 || got_q[2].note !== 6'd10 || got_q[2].dur !== 6'd4) begin
            bad++;
            $display("FAIL song_change_decode_abort: got t=%0d want t=%0d (10/4)",
                     st_q.size() >= 3 ? st_q[2] : -1, s2 + 12);
        end
        play = 1'b0;
    endtask

    task automatic test_reset_mid_song();
        int s1;
        bit checked;
        s1 = -1; checked = 1'b0;
        do_reset();
        song_sel = 2'd0; note_done = 1'b0; play = 1'b1;
        for (int t = 1; t <= 30 && !checked; t++) begin
            step();
            if (s1 >= 0 && t == s1 + 9) begin
                total++;
                if ({rom_addr, note_to_load, duration_to_load, new_note, song_done} !== 21'd0) begin
                    bad++;
                    $display("FAIL reset_mid_song: got addr=%0d note=%0d dur=%0d nn=%0b sd=%0b want all 0",
                             rom_addr, note_to_load, duration_to_load, new_note, song_done);
                end
                checked = 1'b1;
            end
            if (new_note && s1 < 0) s1 = t;
            if (s1 >= 0 && t == s1 + 4) note_done = 1'b1;
            if (s1 >= 0 && t == s1 + 8) reset = 1'b1;
        end
        total++;
        if (checked !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_song_reached: got %0b want 1", checked);
        end
        reset = 1'b0;
        play  = 1'b0;
    endtask

    task automatic test_random();
        int unsigned len;
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(8, 1);
            for (int i = 0; i < 32; i++)
                rom[96 + i] = {6'($urandom), 6'($urandom_range(63, 1))};
            rom[96 + len] = {6'($urandom), 6'd0};
            do_reset();
            run_song(3, 1, 6, 1'b1, 800);
            build_expected(3);
            compare_song("random");
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            rom[i] = {6'($urandom), 6'($urandom_range(63, 1))};
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd12, 6'd2};
        rom[2] = {6'd0, 6'd3};
        rom[3] = {6'($urandom), 6'd0};

        test_reset();
        test_basic();
        test_wrap32();
        test_arm_guard();
        test_pause();
        test_song_change();
        test_reset_mid_song();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
